// File: rtl/ram_8x72_pkg.sv
// Shared constants and types for the 8x72 RAM arbiter.
// Port ids double as bit positions in the arbiter's one-hot grant vector.
package ram_8x72_pkg;

    localparam int DATA_W = 72;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACCESS,
        ST_RDWAIT
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational, one-hot grant indexed by port id.
// When both ports request, the port that was not granted last wins.
module rr_arb2
    import ram_8x72_pkg::*;
(
    input  logic       i_a_req,
    input  logic       i_b_req,
    input  logic       i_last_grant,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_a_req && (!i_b_req || i_last_grant == PORT_B)) begin
            o_gnt[PORT_A] = 1'b1;
        end else if (i_b_req) begin
            o_gnt[PORT_B] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_8x72_arbiter.sv
// Shares one external 8x72 flop RAM between requesters A and B: a clear sweep after
// reset, then one serialised read or write at a time under round-robin arbitration.
module ram_8x72_arbiter
    import ram_8x72_pkg::*;
#(
    parameter int                 RD_LAT   = 0,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_init_done,

    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic              o_a_ack,
    output logic [DATA_W-1:0] o_a_rdata,
    output logic              o_a_rvalid,

    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic              o_b_ack,
    output logic [DATA_W-1:0] o_b_rdata,
    output logic              o_b_rvalid,

    output logic              o_ram_wr_n,
    output logic [ADDR_W-1:0] o_ram_add,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_last_grant;
    logic                r_we;
    logic                r_init_done;
    logic                r_ram_wr_n;
    logic [ADDR_W-1:0]   r_ram_add;
    logic [DATA_W-1:0]   r_ram_wdata;

    logic [1:0]          w_gnt;
    logic                w_sel;
    logic                w_capture;
    logic                w_req   [2];
    logic                w_we    [2];
    logic [ADDR_W-1:0]   w_addr  [2];
    logic [DATA_W-1:0]   w_wdata [2];

    assign w_req[0]   = i_a_req;
    assign w_req[1]   = i_b_req;
    assign w_we[0]    = i_a_we;
    assign w_we[1]    = i_b_we;
    assign w_addr[0]  = i_a_addr;
    assign w_addr[1]  = i_b_addr;
    assign w_wdata[0] = i_a_wdata;
    assign w_wdata[1] = i_b_wdata;

    rr_arb2 u_arb (
        .i_a_req      (w_req[0]),
        .i_b_req      (w_req[1]),
        .i_last_grant (r_last_grant),
        .o_gnt        (w_gnt)
    );

    assign w_sel = w_gnt[PORT_B];

    // Read data is on ram_rdata in the ACCESS cycle (RD_LAT=0) or the RDWAIT cycle.
    assign w_capture = (r_state == ST_RDWAIT) ||
                       (r_state == ST_ACCESS && !r_we && RD_LAT == 0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_last_grant <= PORT_B;
            r_we         <= 1'b0;
            r_init_done  <= 1'b0;
            r_ram_wr_n   <= 1'b1;
            r_ram_add    <= '0;
            r_ram_wdata  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ram_wr_n  <= 1'b0;
                    r_ram_add   <= r_cnt;
                    r_ram_wdata <= INIT_VAL;
                    r_cnt       <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_ram_add    <= w_addr[w_sel];
                        r_ram_wdata  <= w_wdata[w_sel];
                        r_ram_wr_n   <= ~w_we[w_sel];
                        r_we         <= w_we[w_sel];
                        r_last_grant <= w_sel;
                        r_state      <= ST_ACCESS;
                    end else begin
                        r_ram_wr_n   <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    r_ram_wr_n <= 1'b1;
                    if (!r_we && RD_LAT != 0) begin
                        r_state <= ST_RDWAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RDWAIT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    // Per-port ack pulse and read-data return; r_last_grant names the port in flight.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic              r_ack;
        logic              r_rvalid;
        logic [DATA_W-1:0] r_rdata;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_ack    <= 1'b0;
                r_rvalid <= 1'b0;
                r_rdata  <= '0;
            end else begin
                r_ack    <= (r_state == ST_IDLE) && w_gnt[gi];
                r_rvalid <= w_capture && (r_last_grant == 1'(gi));
                if (w_capture && (r_last_grant == 1'(gi))) begin
                    r_rdata <= i_ram_rdata;
                end
            end
        end
    end

    assign o_init_done = r_init_done;
    assign o_ram_wr_n  = r_ram_wr_n;
    assign o_ram_add   = r_ram_add;
    assign o_ram_wdata = r_ram_wdata;
    assign o_a_ack     = g_port[0].r_ack;
    assign o_a_rvalid  = g_port[0].r_rvalid;
    assign o_a_rdata   = g_port[0].r_rdata;
    assign o_b_ack     = g_port[1].r_ack;
    assign o_b_rvalid  = g_port[1].r_rvalid;
    assign o_b_rdata   = g_port[1].r_rdata;

endmodule

// File: tb/tb_ram_8x72_arbiter.sv
// Directed bench for ram_8x72_arbiter: instance 0 uses RD_LAT=0, instance 1 RD_LAT=1,
// each wired to its own behavioural 8x72 RAM preloaded with a non-zero pattern.
module tb_ram_8x72_arbiter;

    localparam logic [71:0] PAT   = 72'hAB_CDEF_0123_4567_89AB;
    localparam logic [71:0] XPAT  = 72'h5A_5A12_3400_00FF_FFC3;
    localparam logic [71:0] JUNK  = 72'hDE_ADBE_EFDE_ADBE_EF77;

    logic        clk = 1'b0;
    logic        fill;
    logic        rst        [2];
    logic        init_done  [2];
    logic        req        [2][2];
    logic        we         [2][2];
    logic [2:0]  addr       [2][2];
    logic [71:0] wdata      [2][2];
    logic        ack        [2][2];
    logic        rvalid     [2][2];
    logic [71:0] rdata      [2][2];
    logic        ram_wr_n   [2];
    logic [2:0]  ram_add    [2];
    logic [71:0] ram_wdata  [2];
    logic [71:0] ram_rdata  [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [71:0] mem [8];
        logic [71:0] rd_q;

        ram_8x72_arbiter #(.RD_LAT(gi)) u_dut (
            .i_clk       (clk),
            .i_rst       (rst[gi]),
            .o_init_done (init_done[gi]),
            .i_a_req     (req[gi][0]),
            .i_a_we      (we[gi][0]),
            .i_a_addr    (addr[gi][0]),
            .i_a_wdata   (wdata[gi][0]),
            .o_a_ack     (ack[gi][0]),
            .o_a_rdata   (rdata[gi][0]),
            .o_a_rvalid  (rvalid[gi][0]),
            .i_b_req     (req[gi][1]),
            .i_b_we      (we[gi][1]),
            .i_b_addr    (addr[gi][1]),
            .i_b_wdata   (wdata[gi][1]),
            .o_b_ack     (ack[gi][1]),
            .o_b_rdata   (rdata[gi][1]),
            .o_b_rvalid  (rvalid[gi][1]),
            .o_ram_wr_n  (ram_wr_n[gi]),
            .o_ram_add   (ram_add[gi]),
            .o_ram_wdata (ram_wdata[gi]),
            .i_ram_rdata (ram_rdata[gi])
        );

        always @(posedge clk) begin
            if (fill) begin
                for (int i = 0; i < 8; i++) mem[i] <= JUNK;
            end else if (!ram_wr_n[gi]) begin
                mem[ram_add[gi]] <= ram_wdata[gi];
            end
            rd_q <= mem[ram_add[gi]];
        end

        assign ram_rdata[gi] = (gi == 0) ? mem[ram_add[gi]] : rd_q;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on an idle instance; checks ack/rvalid latency and port isolation.
    task automatic op(input int d, input int p, input logic w, input logic [2:0] ad,
                      input logic [71:0] wd, output logic [71:0] rd);
        int n;
        req[d][p]   = 1'b1;
        we[d][p]    = w;
        addr[d][p]  = ad;
        wdata[d][p] = wd;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack[d][p] && n < 20);
        check($sformatf("ack_lat d%0d p%0d", d, p), 72'(n), 72'd1);
        check($sformatf("ack_rv_excl d%0d p%0d", d, p), 72'(rvalid[d][p]), 72'd0);
        req[d][p] = 1'b0;
        rd = '0;
        if (w) begin
            tick();
        end else begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!rvalid[d][p] && n < 20);
            check($sformatf("rv_lat d%0d p%0d", d, p), 72'(n), (d == 0) ? 72'd1 : 72'd2);
            check($sformatf("other_rv d%0d p%0d", d, p), 72'(rvalid[d][1-p]), 72'd0);
            rd = rdata[d][p];
        end
        $display("op dut%0d port %s %s @%0d wdata %h rdata %h", d, (p == 0) ? "A" : "B",
                 w ? "WR" : "RD", ad, wd, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] rd;
        fill = 1'b1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
            end
        end
        tick();
        fill = 1'b0;
        tick();
        check("rst wr_n", 72'(ram_wr_n[0]), 72'd1);
        check("rst add", 72'(ram_add[0]), 72'd0);
        check("rst wdata", ram_wdata[0], 72'd0);
        check("rst init_done", 72'(init_done[0]), 72'd0);
        check("rst a_ack", 72'(ack[0][0]), 72'd0);
        check("rst b_rvalid", 72'(rvalid[0][1]), 72'd0);
        check("rst a_rdata", rdata[0][0], 72'd0);

        // Sweep with A holding a read of word 5 throughout INIT.
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 3'd5;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("sweep wr_n %0d", k), 72'(ram_wr_n[0]), 72'd0);
            check($sformatf("sweep add %0d", k), 72'(ram_add[0]), 72'(k));
            check($sformatf("sweep wdata %0d", k), ram_wdata[0], 72'd0);
            check($sformatf("sweep init_done %0d", k), 72'(init_done[0]), (k == 7) ? 72'd1 : 72'd0);
            check($sformatf("sweep no_ack %0d", k), 72'(ack[0][0]), 72'd0);
        end
        tick();
        check("held a_ack", 72'(ack[0][0]), 72'd1);
        check("held wr_n", 72'(ram_wr_n[0]), 72'd1);
        req[0][0] = 1'b0;
        tick();
        check("held a_rvalid", 72'(rvalid[0][0]), 72'd1);
        check("held a_rdata5", rdata[0][0], 72'd0);
        $display("op dut0 port A RD @5 (held through init) rdata %h", rdata[0][0]);

        // Write then read-back through the other port.
        op(0, 0, 1'b1, 3'd3, PAT, rd);
        op(0, 1, 1'b0, 3'd3, '0, rd);
        check("raw b_rdata3", rd, PAT);
        check("raw a_rdata_hold", rdata[0][0], 72'd0);
        op(0, 0, 1'b0, 3'd5, '0, rd);
        check("a_rdata5", rd, 72'd0);
        op(0, 1, 1'b1, 3'd0, XPAT, rd);

        // Both ports hammer reads: A, -, B, -, A, ...
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 3'd0;
        req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 3'd3;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("rr ackA c%0d", i), 72'(ack[0][0]), (i % 4 == 1) ? 72'd1 : 72'd0);
            check($sformatf("rr ackB c%0d", i), 72'(ack[0][1]), (i % 4 == 3) ? 72'd1 : 72'd0);
        end
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        check("rr a_rdata0", rdata[0][0], XPAT);
        check("rr b_rdata3", rdata[0][1], PAT);
        $display("op dut0 round-robin A RD @0 / B RD @3 rdata %h / %h", rdata[0][0], rdata[0][1]);

        // RD_LAT=1 instance.
        op(1, 0, 1'b1, 3'd7, 72'h1, rd);
        op(1, 0, 1'b1, 3'd0, 72'h2, rd);
        op(1, 0, 1'b0, 3'd7, '0, rd);
        check("lat1 rd7", rd, 72'h1);
        op(1, 0, 1'b0, 3'd0, '0, rd);
        check("lat1 rd0", rd, 72'h2);

        // Reset during a B read ACCESS.
        req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 3'd3;
        tick();
        check("mid b_ack", 72'(ack[0][1]), 72'd1);
        rst[0] = 1'b1;
        req[0][1] = 1'b0;
        tick();
        check("mid b_rvalid", 72'(rvalid[0][1]), 72'd0);
        check("mid b_rdata", rdata[0][1], 72'd0);
        check("mid init_done", 72'(init_done[0]), 72'd0);
        check("mid wr_n", 72'(ram_wr_n[0]), 72'd1);
        rst[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("resweep add %0d", k), 72'(ram_add[0]), 72'(k));
            check($sformatf("resweep wr_n %0d", k), 72'(ram_wr_n[0]), 72'd0);
            check($sformatf("resweep init_done %0d", k), 72'(init_done[0]), (k == 7) ? 72'd1 : 72'd0);
            check($sformatf("resweep b_rvalid %0d", k), 72'(rvalid[0][1]), 72'd0);
        end
        tick();
        op(0, 0, 1'b0, 3'd3, '0, rd);
        check("cleared rd3", rd, 72'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
